// File: rtl/lw_sha_core_arbiter_if.sv
// Requester-side and core-side signal bundle for lw_sha_core_arbiter.
// The slave modport is the arbiter; the master modport drives requesters and the core model.
interface lw_sha_core_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 32
);
  logic [NUM_REQ-1:0]           req_i;
  logic [4*NUM_REQ-1:0]         opcode_i;
  logic [WORD_SIZE*NUM_REQ-1:0] data_i;
  logic [NUM_REQ-1:0]           valid_i;
  logic [NUM_REQ-1:0]           last_i;
  logic [NUM_REQ-1:0]           ready_o;
  logic [NUM_REQ-1:0]           grant_o;
  logic [NUM_REQ-1:0]           done_o;
  logic [NUM_REQ-1:0]           err_o;
  logic                         core_start_o;
  logic [3:0]                   core_opcode_o;
  logic [WORD_SIZE-1:0]         core_data_o;
  logic                         core_valid_o;
  logic                         core_last_o;
  logic                         core_abort_o;
  logic                         core_ready_i;
  logic                         core_idle_i;
  logic                         core_done_i;
  logic                         timeout_o;

  modport slave (
    input  req_i, opcode_i, data_i, valid_i, last_i,
    input  core_ready_i, core_idle_i, core_done_i,
    output ready_o, grant_o, done_o, err_o,
    output core_start_o, core_opcode_o, core_data_o, core_valid_o,
    output core_last_o, core_abort_o, timeout_o
  );

  modport master (
    output req_i, opcode_i, data_i, valid_i, last_i,
    output core_ready_i, core_idle_i, core_done_i,
    input  ready_o, grant_o, done_o, err_o,
    input  core_start_o, core_opcode_o, core_data_o, core_valid_o,
    input  core_last_o, core_abort_o, timeout_o
  );
endinterface

// File: rtl/lw_sha_core_arbiter.sv
// Job-granular round-robin arbiter sharing one SHA/HMAC core between NUM_REQ requesters.
// Optional watchdog abort enabled by defining LW_SHA_ARB_WDOG_EN.
module lw_sha_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk_i,
  input logic                  rst_i,
  lw_sha_core_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_STREAM     = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_ABORT_WAIT = 3'd4,
    S_RELEASE    = 3'd5
  } state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 ||
      (WORD_SIZE != 32 && WORD_SIZE != 64)) begin : g_param_check
    $error("lw_sha_core_arbiter: unsupported parameter set");
  end

  // First requesting index at or above ptr, wrapping; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] owner);
    if (int'(owner) == NUM_REQ - 1) return '0;
    else return owner + IDX_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [3:0]           opcode_q, opcode_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 abort_q, abort_d;
  logic [IDX_W:0]       pick_s;
  logic [NUM_REQ-1:0]   ready_s;
  logic [WORD_SIZE-1:0] data_s;
  logic                 owner_req_s;
  logic                 accept_s;
  logic                 wdog_hit_s;

  assign pick_s      = rr_pick(bus.req_i, rr_ptr_q);
  assign owner_req_s = bus.req_i[owner_q];
  assign accept_s    = (state_q == S_STREAM) && bus.valid_i[owner_q] && bus.core_ready_i;

  // Next-state, job sequencing and streaming pass-through.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    opcode_d = opcode_q;
    last_d   = last_q;
    done_d   = '0;
    err_d    = '0;
    abort_d  = 1'b0;
    ready_s  = '0;
    data_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_s[IDX_W] && bus.core_idle_i) begin
          owner_d  = pick_s[IDX_W-1:0];
          grant_d  = NUM_REQ'(1) << pick_s[IDX_W-1:0];
          opcode_d = bus.opcode_i[int'(pick_s[IDX_W-1:0])*4 +: 4];
          state_d  = S_START;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        ready_s[owner_q] = bus.core_ready_i;
        data_s           = bus.data_i[int'(owner_q)*WORD_SIZE +: WORD_SIZE];
        if (!owner_req_s || wdog_hit_s) begin
          abort_d = 1'b1;
          state_d = S_ABORT_WAIT;
        end else if (accept_s && bus.last_i[owner_q]) begin
          last_d  = 1'b1;
          state_d = S_WAIT_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_WAIT_DONE: begin
        // A completing hash takes priority over a simultaneous request drop.
        if (bus.core_done_i) begin
          done_d  = grant_q;
          state_d = S_RELEASE;
        end else if (!owner_req_s || wdog_hit_s) begin
          abort_d = 1'b1;
          state_d = S_ABORT_WAIT;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_RELEASE: begin
        grant_d  = '0;
        last_d   = 1'b0;
        opcode_d = 4'h0;
        rr_ptr_d = ptr_after(owner_q);
        state_d  = S_IDLE;
      end
      S_ABORT_WAIT: begin
        if (bus.core_idle_i) begin
          err_d    = grant_q;
          grant_d  = '0;
          last_d   = 1'b0;
          opcode_d = 4'h0;
          rr_ptr_d = ptr_after(owner_q);
          state_d  = S_IDLE;
        end else begin
          state_d  = S_ABORT_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      opcode_q <= 4'h0;
      last_q   <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      opcode_q <= opcode_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

`ifdef LW_SHA_ARB_WDOG_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              active_s;

  assign active_s = (state_q == S_STREAM) || (state_q == S_WAIT_DONE);
  // Firing one count early lets the registered pulse coincide with the count reaching TIMEOUT-1.
  assign wdog_hit_s = active_s && !accept_s && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 2));

  // Watchdog count: cleared on accepted words and outside the streaming states.
  always_comb begin
    wdog_d    = '0;
    timeout_d = wdog_hit_s && (state_d == S_ABORT_WAIT);
    if (active_s) begin
      if (accept_s) wdog_d = '0;
      else          wdog_d = wdog_q + WDOG_W'(1);
    end else begin
      wdog_d = '0;
    end
  end

  // Watchdog counter and timeout pulse register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign wdog_hit_s    = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.ready_o       = ready_s;
  assign bus.grant_o       = grant_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
  assign bus.core_start_o  = (state_q == S_START);
  assign bus.core_opcode_o = opcode_q;
  assign bus.core_data_o   = data_s;
  assign bus.core_valid_o  = accept_s;
  assign bus.core_last_o   = last_q;
  assign bus.core_abort_o  = abort_q;

endmodule

// File: doc/lw_sha_core_arbiter.md
Name: lw_sha_core_arbiter

Overview:
Shares one lightweight SHA/HMAC core between NUM_REQ requesters, such as the bus register interface, DMA channels and an internal key-derivation engine. A requester holds the core for a whole job: init, streamed message words, last word, then done. The block arbitrates round-robin at job granularity and sequences the core's start, valid, last and abort strobes. It sits between the requester interfaces and the core's native port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_SIZE, 32, core data word width (32 or 64)
TIMEOUT_CYCLES, 1024, watchdog limit in clocks (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  NUM_REQ  job request per requester; held high for the whole job
opcode_i  in  4*NUM_REQ  opcode per requester; sampled at grant
data_i  in  WORD_SIZE*NUM_REQ  message word per requester
valid_i  in  NUM_REQ  word valid per requester
last_i  in  NUM_REQ  final word of the job; qualified by valid_i
ready_o  out  NUM_REQ  word accepted when valid_i and ready_o are both high
grant_o  out  NUM_REQ  one-hot current owner
done_o  out  NUM_REQ  1-cycle pulse: owner's hash is available
err_o  out  NUM_REQ  1-cycle pulse: owner's job was aborted
core_start_o  out  1  init strobe
core_opcode_o  out  4  opcode of the owner
core_data_o  out  WORD_SIZE  forwarded word
core_valid_o  out  1  word strobe
core_last_o  out  1  last-block flag, held from the last word until done
core_abort_o  out  1  1-cycle abort strobe
core_ready_i  in  1  core accepts a data word
core_idle_i  in  1  core not busy
core_done_i  in  1  hash complete
timeout_o  out  1  watchdog abort pulse

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, rr_ptr = 0. Reset mid-job drops the grant immediately and emits no done or err pulse.
- FSM states: IDLE, START, STREAM, WAIT_DONE, ABORT_WAIT, RELEASE.
- IDLE: when any req_i is high and core_idle_i=1, grant the first requester at or above rr_ptr, wrapping modulo NUM_REQ. grant_o is registered and goes high the next cycle. Latch the owner's opcode. Go to START.
- START: core_start_o=1 for exactly 1 cycle; core_opcode_o holds the latched opcode until RELEASE. Go to STREAM.
- STREAM:
  - ready_o[owner] = core_ready_i; all other ready_o bits are 0.
  - core_valid_o = valid_i[owner] & core_ready_i, combinational pass-through. core_data_o = data_i[owner].
  - When a word with last_i is accepted, set core_last_o and go to WAIT_DONE.
- WAIT_DONE: ready_o=0. On core_done_i go to RELEASE.
- RELEASE: 1 cycle. done_o[owner]=1, clear core_last_o and grant_o, set rr_ptr = owner+1 (mod NUM_REQ). Go to IDLE.
- Abort: if req_i[owner] falls in STREAM or WAIT_DONE, pulse core_abort_o for 1 cycle and go to ABORT_WAIT.
- ABORT_WAIT: hold until core_idle_i=1, then pulse err_o[owner], update rr_ptr as in RELEASE, and go to IDLE.
- Simultaneous core_done_i and req drop in WAIT_DONE: done wins and no abort is issued.
- Requests are never granted while core_idle_i=0, including the cycle after RELEASE.
- Single requester: it is re-granted back-to-back, with a minimum of 2 idle cycles between jobs (RELEASE, IDLE).
- Changes to a non-owner's req_i while a job is active are ignored.
- The opcode is frozen for the job; later changes to opcode_i are ignored.

Optional Feature:
LW_SHA_ARB_WDOG_EN:
- Defined: a counter clears on every accepted word and on entry to STREAM or WAIT_DONE, and increments each cycle in STREAM and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1, the block pulses core_abort_o and timeout_o together for 1 cycle, then takes the ABORT_WAIT path and pulses err_o[owner].
- Undefined: timeout_o is tied to 0, there is no counter, and the TIMEOUT_CYCLES parameter is ignored.

Test Plan:
- req_i=0001, 3 words with last on word 3, core_done_i 20 cycles later -> core_start_o 1 cycle after the grant, core_valid_o 3 times, core_last_o set from word 3 until RELEASE, done_o[0] pulse, grant_o=0.
- req_i=1111 held, each job 1 word -> grant order 0,1,2,3,0; rr_ptr wraps correctly.
- Owner 2 drops req in STREAM, core_idle_i rises 5 cycles later -> one core_abort_o pulse, err_o[2] 5 cycles later, no done_o, next grant goes to 3.
- core_done_i and req drop in the same cycle in WAIT_DONE -> done_o pulses, core_abort_o stays 0.
- rst_i asserted mid-STREAM -> all outputs 0 asynchronously; after release, req_i=0100 is granted with rr_ptr back at 0.
- With LW_SHA_ARB_WDOG_EN and TIMEOUT_CYCLES=16, stall valid_i in STREAM -> timeout_o and core_abort_o pulse on cycle 16, followed by err_o.
